// File: rtl/serial_arith_pkg.sv
// serial_arith_pkg: shared types and helpers for the bit-serial arithmetic blocks.
//   state_t      : controller states (IDLE, ADD, DONE), 2-bit encoding
//   count_width  : bit-counter width for a given operand width
package serial_arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  // The counter only has to reach width-1, so clog2(width) bits are enough.
  function automatic int count_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/fa_cell.sv
// fa_cell: purely combinational 1-bit full adder.
//   x, y : addend bits
//   ci   : carry in
//   s    : sum bit
//   co   : carry out
module fa_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  always_comb begin
    s  = x ^ y ^ ci;
    co = (x & y) | (x & ci) | (y & ci);
  end

endmodule

// File: rtl/serial_adder_nbit.sv
// serial_adder_nbit: bit-serial WIDTH-bit adder. Operands are captured in
// parallel on an accepted start, then summed LSB-first through a single
// full-adder cell with a registered carry. {cout,sum} = a + b + cin.
//   clk, rst  : rising-edge clock, synchronous active-high reset
//   start     : request; accepted in IDLE or DONE
//   a, b, cin : operands, captured on acceptance
//   busy      : high while bits are being processed
//   done      : one-cycle pulse when sum/cout are valid
//   sum, cout : result, held until the next completion
//   ovf       : two's-complement overflow, present only when
//               SERIAL_ADDER_OVF_EN is defined
module serial_adder_nbit
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             cout
);

  localparam int CW = count_width(WIDTH);

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_sr, b_sr, sum_sr;
  logic             carry;
  logic [CW-1:0]    count;
  logic             bit_s, bit_co;
  logic             accept, last;

  fa_cell u_fa (
    .x  (a_sr[0]),
    .y  (b_sr[0]),
    .ci (carry),
    .s  (bit_s),
    .co (bit_co)
  );

  always_comb begin
    accept = start && ((state == IDLE) || (state == DONE));
    last   = (state == ADD) && (count == CW'(WIDTH - 1));
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = ADD;
      ADD:     if (last)  state_nx = DONE;
      DONE:    state_nx = start ? ADD : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs decoded from registered state only
  always_comb begin
    busy = (state == ADD);
    done = (state == DONE);
  end

  // Datapath: operand/sum shift registers, carry flop, bit counter, result
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      carry  <= 1'b0;
      count  <= '0;
      sum    <= '0;
      cout   <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf    <= 1'b0;
`endif
    end else if (accept) begin
      a_sr   <= a;
      b_sr   <= b;
      sum_sr <= '0;
      carry  <= cin;
      count  <= '0;
    end else if (state == ADD) begin
      a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
      b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
      sum_sr <= {bit_s, sum_sr[WIDTH-1:1]};
      carry  <= bit_co;
      count  <= count + CW'(1);
      if (last) begin
        // On the last edge the MSB bit is still in flight, so the result
        // is assembled from the cell output rather than from sum_sr.
        sum  <= {bit_s, sum_sr[WIDTH-1:1]};
        cout <= bit_co;
`ifdef SERIAL_ADDER_OVF_EN
        // carry here is the carry into the MSB; bit_co is the carry out of it.
        ovf  <= carry ^ bit_co;
`endif
      end
    end
  end

endmodule

// File: tb/tb_serial_adder_nbit.sv
module tb_serial_adder_nbit;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, start, cin;
  logic [W-1:0] a, b, sum;
  logic         busy, done, cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_adder_nbit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
`ifdef SERIAL_ADDER_OVF_EN
    .ovf   (ovf),
`endif
    .cout  (cout)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] s;
    logic         c;
    logic         v;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Pulse start for one cycle; returns at the negedge after the accepting edge.
  task automatic launch(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
    @(negedge clk);
    a = av; b = bv; cin = cv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
  endtask

  // Counts clock edges until done is seen, bounded by limit.
  task automatic wait_done(input int limit, output int edges, output int nbusy);
    edges = 0;
    nbusy = 0;
    while (done !== 1'b1 && edges < limit) begin
      if (busy === 1'b1) nbusy++;
      @(negedge clk);
      edges++;
    end
  endtask

  initial begin
    int edges, nbusy;

    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[5] = '{8'h40, 8'h20, 1'b0, 8'h60, 1'b0, 1'b0};
    vecs[6] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
    vecs[7] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[8] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0};
    vecs[9] = '{8'hC3, 8'hA5, 1'b0, 8'h68, 1'b1, 1'b1};

    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("reset busy", 32'(busy), 0);
    chk("reset done", 32'(done), 0);
    chk("reset sum",  32'(sum),  0);
    chk("reset cout", 32'(cout), 0);
    rst = 1'b0;

    for (int unsigned i = 0; i < 10; i++) begin
      launch(vecs[i].a, vecs[i].b, vecs[i].cin);
      wait_done(W + 6, edges, nbusy);
      chk($sformatf("v%0d latency", i), 32'(edges), W);
      chk($sformatf("v%0d busy cycles", i), 32'(nbusy), W);
      chk($sformatf("v%0d busy at done", i), 32'(busy), 0);
      chk($sformatf("v%0d sum", i), 32'(sum), 32'(vecs[i].s));
      chk($sformatf("v%0d cout", i), 32'(cout), 32'(vecs[i].c));
`ifdef SERIAL_ADDER_OVF_EN
      chk($sformatf("v%0d ovf", i), 32'(ovf), 32'(vecs[i].v));
`endif
      @(negedge clk);
      chk($sformatf("v%0d done pulse width", i), 32'(done), 0);
      chk($sformatf("v%0d sum held", i), 32'(sum), 32'(vecs[i].s));
    end

    // start during busy is ignored
    launch(8'h10, 8'h20, 1'b0);
    @(negedge clk);
    @(negedge clk);
    a = 8'h11; b = 8'h22; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(W + 6, edges, nbusy);
    chk("ignored start latency", 32'(edges), W - 3);
    chk("ignored start sum", 32'(sum), 32'h30);
    chk("ignored start cout", 32'(cout), 0);
    @(negedge clk);
    chk("ignored start idle busy", 32'(busy), 0);
    chk("ignored start idle done", 32'(done), 0);

    // back-to-back: start held through DONE
    @(negedge clk);
    a = 8'h05; b = 8'h06; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    a = 8'h01; b = 8'h02;
    wait_done(W + 6, edges, nbusy);
    chk("b2b first latency", 32'(edges), W);
    chk("b2b first sum", 32'(sum), 32'h0B);
    @(negedge clk);
    start = 1'b0;
    chk("b2b reload busy", 32'(busy), 1);
    chk("b2b reload done", 32'(done), 0);
    wait_done(W + 6, edges, nbusy);
    chk("b2b second latency", 32'(edges), W);
    chk("b2b second sum", 32'(sum), 32'h03);
    chk("b2b second cout", 32'(cout), 0);

    // reset in the 4th ADD cycle
    launch(8'h5A, 8'h3C, 1'b0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst busy", 32'(busy), 0);
    chk("midrst done", 32'(done), 0);
    chk("midrst sum",  32'(sum),  0);
    chk("midrst cout", 32'(cout), 0);
`ifdef SERIAL_ADDER_OVF_EN
    chk("midrst ovf",  32'(ovf),  0);
`endif
    wait_done(W + 6, edges, nbusy);
    chk("midrst no done", 32'(edges), W + 6);
    chk("midrst no busy", 32'(nbusy), 0);
    launch(8'h21, 8'h43, 1'b1);
    wait_done(W + 6, edges, nbusy);
    chk("post-rst latency", 32'(edges), W);
    chk("post-rst sum", 32'(sum), 32'h65);
    chk("post-rst cout", 32'(cout), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
